// File: rtl/gpu_sched_pkg.sv
// Shared types and constants for the stage dispatch scheduler.
// Optional queue aging is enabled by defining SCHED_AGING_EN.
package gpu_sched_pkg;

    localparam int DATA_W_DEF = 256;
    localparam int PC_W_DEF   = 16;
    localparam int SIZE_W_DEF = 16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_POP   = 3'd1,
        ST_LOAD  = 3'd2,
        ST_WRITE = 3'd3,
        ST_FOUND = 3'd4
    } state_t;

    localparam logic [1:0] GRANT_NONE = 2'd0;
    localparam logic [1:0] GRANT_T    = 2'd1;
    localparam logic [1:0] GRANT_L    = 2'd2;
    localparam logic [1:0] GRANT_P    = 2'd3;

endpackage

// File: rtl/sched_prio_pick.sv
// Combinational winner selection: an aged queue (lighting first) beats
// the fixed projection > lighting > transformation order.
import gpu_sched_pkg::*;

module sched_prio_pick #(
    parameter int SIZE_W = SIZE_W_DEF
) (
    input  logic [SIZE_W-1:0] t_size,
    input  logic [SIZE_W-1:0] l_size,
    input  logic [SIZE_W-1:0] p_size,
    input  logic              t_aged,
    input  logic              l_aged,
    output logic [1:0]        pick
);

    logic t_any;
    logic l_any;
    logic p_any;

    assign t_any = (t_size != '0);
    assign l_any = (l_size != '0);
    assign p_any = (p_size != '0);

    always_comb begin
        pick = GRANT_NONE;
        if (l_aged && l_any) begin
            pick = GRANT_L;
        end else if (t_aged && t_any) begin
            pick = GRANT_T;
        end else if (p_any) begin
            pick = GRANT_P;
        end else if (l_any) begin
            pick = GRANT_L;
        end else if (t_any) begin
            pick = GRANT_T;
        end
    end

endmodule

// File: rtl/stage_dispatch_scheduler.sv
// Picks a non-empty stage queue, pops one record and bulk-loads it into the
// register file. Define SCHED_AGING_EN to add starvation-avoidance aging.
import gpu_sched_pkg::*;

module stage_dispatch_scheduler #(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int PC_W      = PC_W_DEF,
  parameter int SIZE_W    = SIZE_W_DEF,
  parameter int AGE_LIMIT = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              request_new_pc,
  input  logic [PC_W-1:0]   t_pc,
  input  logic [PC_W-1:0]   l_pc,
  input  logic [PC_W-1:0]   p_pc,
  input  logic [SIZE_W-1:0] t_size,
  input  logic [SIZE_W-1:0] l_size,
  input  logic [SIZE_W-1:0] p_size,
  input  logic [DATA_W-1:0] t_ret_regs,
  input  logic [DATA_W-1:0] l_ret_regs,
  input  logic [DATA_W-1:0] p_ret_regs,
  output logic              t_reading,
  output logic              l_reading,
  output logic              p_reading,
  output logic [PC_W-1:0]   new_pc,
  output logic [1:0]        grant,
  output logic [DATA_W-1:0] queue_regs,
  output logic              writing_regs,
  output logic              pc_found,
  output logic              no_work,
  output logic              busy
);

  state_t     state;
  state_t     state_nxt;
  logic [1:0] pick;
  logic       t_aged;
  logic       l_aged;
  logic       take;
  logic       t_rd_nxt;
  logic       l_rd_nxt;
  logic       p_rd_nxt;
  logic       wr_nxt;
  logic       found_nxt;
  logic       no_work_nxt;

  sched_prio_pick #(.SIZE_W(SIZE_W)) u_pick (
    .t_size (t_size),
    .l_size (l_size),
    .p_size (p_size),
    .t_aged (t_aged),
    .l_aged (l_aged),
    .pick   (pick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Each state lasts exactly one cycle except IDLE, so every pulse is one cycle wide.
  always_comb begin
    state_nxt   = state;
    take        = 1'b0;
    t_rd_nxt    = 1'b0;
    l_rd_nxt    = 1'b0;
    p_rd_nxt    = 1'b0;
    wr_nxt      = 1'b0;
    found_nxt   = 1'b0;
    no_work_nxt = 1'b0;
    case (state)
      ST_IDLE: begin
        if (request_new_pc) begin
          if (pick == GRANT_NONE) begin
            no_work_nxt = 1'b1;
          end else begin
            take      = 1'b1;
            t_rd_nxt  = (pick == GRANT_T);
            l_rd_nxt  = (pick == GRANT_L);
            p_rd_nxt  = (pick == GRANT_P);
            state_nxt = ST_POP;
          end
        end
      end
      ST_POP:   state_nxt = ST_LOAD;
      ST_LOAD: begin
        wr_nxt    = 1'b1;
        state_nxt = ST_WRITE;
      end
      ST_WRITE: begin
        found_nxt = 1'b1;
        state_nxt = ST_FOUND;
      end
      ST_FOUND: state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      t_reading    <= 1'b0;
      l_reading    <= 1'b0;
      p_reading    <= 1'b0;
      writing_regs <= 1'b0;
      pc_found     <= 1'b0;
      no_work      <= 1'b0;
      grant        <= GRANT_NONE;
      new_pc       <= '0;
      queue_regs   <= '0;
    end else begin
      t_reading    <= t_rd_nxt;
      l_reading    <= l_rd_nxt;
      p_reading    <= p_rd_nxt;
      writing_regs <= wr_nxt;
      pc_found     <= found_nxt;
      no_work      <= no_work_nxt;
      if (take) begin
        grant <= pick;
        case (pick)
          GRANT_P: new_pc <= p_pc;
          GRANT_L: new_pc <= l_pc;
          default: new_pc <= t_pc;
        endcase
      end
      // Queue data is valid during LOAD, one cycle after the pop pulse.
      if (state == ST_LOAD) begin
        case (grant)
          GRANT_P: queue_regs <= p_ret_regs;
          GRANT_L: queue_regs <= l_ret_regs;
          default: queue_regs <= t_ret_regs;
        endcase
      end
    end
  end

  assign busy = (state != ST_IDLE);

`ifdef SCHED_AGING_EN
  localparam int CNT_W = ($clog2(AGE_LIMIT + 1) > 4) ? $clog2(AGE_LIMIT + 1) : 4;

  logic [CNT_W-1:0] t_age;
  logic [CNT_W-1:0] l_age;

  assign t_aged = (t_age >= CNT_W'(AGE_LIMIT));
  assign l_aged = (l_age >= CNT_W'(AGE_LIMIT));

  // A waiting, bypassed queue ages; a granted or empty queue starts over.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      t_age <= '0;
      l_age <= '0;
    end else if (take) begin
      if ((t_size != '0) && (pick != GRANT_T)) begin
        t_age <= (t_age == '1) ? t_age : t_age + 1'b1;
      end else begin
        t_age <= '0;
      end
      if ((l_size != '0) && (pick != GRANT_L)) begin
        l_age <= (l_age == '1) ? l_age : l_age + 1'b1;
      end else begin
        l_age <= '0;
      end
    end
  end
`else
  assign t_aged = 1'b0;
  assign l_aged = 1'b0;
`endif

endmodule
